// File: rtl/fwd_ctrl_unit.sv
// EX-stage operand forwarding select and load-use stall generation for the 16-bit pipeline.
// Optional macro FWD_STATS_EN adds saturating forwarding/stall event counters.
module fwd_ctrl_unit #(
    parameter int REG_AW = 4,
    parameter int SEL_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    output logic [SEL_W-1:0]  ALUSrcA,
    output logic [SEL_W-1:0]  ALUSrcB,
    output logic              stall
`ifdef FWD_STATS_EN
    ,
    output logic [15:0]       fwd_mem_cnt,
    output logic [15:0]       fwd_wb_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [SEL_W-1:0] SEL_RF    = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_EXMEM = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_MEMWB = SEL_W'(2);

    // The WB tag is not stored: the register file writes before it is read,
    // so a producer three slots back never needs forwarding.
    logic              ex_valid_q, ex_rw_q, ex_ld_q;
    logic [REG_AW-1:0] ex_rd_q;
    logic              mem_valid_q, mem_rw_q;
    logic [REG_AW-1:0] mem_rd_q;
    logic [SEL_W-1:0]  sel_a_q, sel_b_q;
    logic [SEL_W-1:0]  sel_a_d, sel_b_d;
    logic              haz_a, haz_b, issue;

    function automatic logic [SEL_W-1:0] fwd_sel(input logic use_rs, input logic [REG_AW-1:0] rs);
        logic [SEL_W-1:0] sel;
        sel = SEL_RF;
        if (use_rs && rs != '0) begin
            if (ex_valid_q && ex_rw_q && ex_rd_q == rs)
                sel = SEL_EXMEM;
            else if (mem_valid_q && mem_rw_q && mem_rd_q == rs)
                sel = SEL_MEMWB;
        end
        return sel;
    endfunction

    always_comb begin
        haz_a   = id_use_rs1 && id_rs1 != '0 && id_rs1 == ex_rd_q;
        haz_b   = id_use_rs2 && id_rs2 != '0 && id_rs2 == ex_rd_q;
        stall   = !rst && id_valid && !flush && ex_valid_q && ex_ld_q && ex_rw_q
                  && (haz_a || haz_b);
        issue   = id_valid && !flush && !stall;
        sel_a_d = issue ? fwd_sel(id_use_rs1, id_rs1) : SEL_RF;
        sel_b_d = issue ? fwd_sel(id_use_rs2, id_rs2) : SEL_RF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_rw_q     <= 1'b0;
            ex_ld_q     <= 1'b0;
            ex_rd_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_rd_q    <= '0;
            sel_a_q     <= SEL_RF;
            sel_b_q     <= SEL_RF;
        end else begin
            ex_valid_q  <= issue;
            ex_rw_q     <= issue && id_regwrite;
            ex_ld_q     <= issue && id_memread;
            ex_rd_q     <= issue ? id_rd : '0;
            mem_valid_q <= ex_valid_q;
            mem_rw_q    <= ex_rw_q;
            mem_rd_q    <= ex_rd_q;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
        end
    end

    assign ALUSrcA = sel_a_q;
    assign ALUSrcB = sel_b_q;

`ifdef FWD_STATS_EN
    logic [15:0] fwd_mem_cnt_q, fwd_wb_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_mem_cnt_q <= '0;
            fwd_wb_cnt_q  <= '0;
            stall_cnt_q   <= '0;
        end else begin
            if ((sel_a_d == SEL_EXMEM || sel_b_d == SEL_EXMEM) && fwd_mem_cnt_q != 16'hFFFF)
                fwd_mem_cnt_q <= fwd_mem_cnt_q + 16'd1;
            if ((sel_a_d == SEL_MEMWB || sel_b_d == SEL_MEMWB) && fwd_wb_cnt_q != 16'hFFFF)
                fwd_wb_cnt_q <= fwd_wb_cnt_q + 16'd1;
            if (stall && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign fwd_mem_cnt = fwd_mem_cnt_q;
    assign fwd_wb_cnt  = fwd_wb_cnt_q;
    assign stall_cnt   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// Bench for fwd_ctrl_unit: slot-history reference model checked every cycle, plus literal pins.
module tb_fwd_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [3:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic       id_regwrite = 1'b0, id_memread = 1'b0, flush = 1'b0;
    logic [1:0] ALUSrcA, ALUSrcB;
    logic       stall;
`ifdef FWD_STATS_EN
    logic [15:0] fwd_mem_cnt, fwd_wb_cnt, stall_cnt;
`endif

    fwd_ctrl_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush(flush), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .stall(stall)
`ifdef FWD_STATS_EN
        , .fwd_mem_cnt(fwd_mem_cnt), .fwd_wb_cnt(fwd_wb_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    // Model: list of slots that entered EX, newest first (index = distance-1).
    typedef struct packed {
        logic       v;
        logic [3:0] rd;
        logic       rw;
        logic       ld;
    } slot_t;
    slot_t hist[$];
    int exp_a = 0, exp_b = 0;
    int m_mem = 0, m_wb = 0, m_stl = 0;

    function automatic int m_sel(input logic [3:0] rs, input logic use_rs);
        if (!use_rs || rs == 0) return 0;
        for (int d = 0; d < 2; d++)
            if (hist.size() > d && hist[d].v && hist[d].rw && hist[d].rd == rs)
                return d + 1;
        return 0;
    endfunction

    function automatic logic m_stall();
        if (rst || !id_valid || flush || hist.size() == 0) return 1'b0;
        if (!(hist[0].v && hist[0].ld && hist[0].rw) || hist[0].rd == 0) return 1'b0;
        return (id_use_rs1 && id_rs1 == hist[0].rd) || (id_use_rs2 && id_rs2 == hist[0].rd);
    endfunction

    always @(posedge clk) begin
        logic st, real_ins;
        slot_t s;
        if (rst) begin
            hist.delete();
            exp_a = 0; exp_b = 0;
            m_mem = 0; m_wb = 0; m_stl = 0;
        end else begin
            st       = m_stall();
            real_ins = id_valid && !flush && !st;
            exp_a    = real_ins ? m_sel(id_rs1, id_use_rs1) : 0;
            exp_b    = real_ins ? m_sel(id_rs2, id_use_rs2) : 0;
            s.v  = real_ins;
            s.rd = real_ins ? id_rd : 4'd0;
            s.rw = real_ins && id_regwrite;
            s.ld = real_ins && id_memread;
            hist.push_front(s);
            if (hist.size() > 2) void'(hist.pop_back());
            if ((exp_a == 1 || exp_b == 1) && m_mem < 65535) m_mem++;
            if ((exp_a == 2 || exp_b == 2) && m_wb < 65535) m_wb++;
            if (st && m_stl < 65535) m_stl++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_ALUSrcA", 32'(ALUSrcA), 32'(exp_a));
            check("model_ALUSrcB", 32'(ALUSrcB), 32'(exp_b));
            check("model_stall", 32'(stall), 32'(m_stall()));
`ifdef FWD_STATS_EN
            check("model_fwd_mem_cnt", 32'(fwd_mem_cnt), 32'(m_mem));
            check("model_fwd_wb_cnt", 32'(fwd_wb_cnt), 32'(m_wb));
            check("model_stall_cnt", 32'(stall_cnt), 32'(m_stl));
`endif
        end
    end

    task automatic drive(input logic v, input logic [3:0] rs1, input logic u1,
                         input logic [3:0] rs2, input logic u2, input logic [3:0] rd,
                         input logic rw, input logic ld, input logic fl);
        id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_rd = rd; id_regwrite = rw; id_memread = ld; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [3:0] rs1, input logic u1, input logic [3:0] rs2,
                      input logic u2, input logic [3:0] rd, input logic ld);
        drive(1, rs1, u1, rs2, u2, rd, 1, ld, 0);
        tick();
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1;
        tick(); tick();
        chk_en = 1;
        check("reset_A", 32'(ALUSrcA), 0);
        check("reset_B", 32'(ALUSrcB), 0);
        check("reset_stall", 32'(stall), 0);
        rst = 0;

        // back-to-back dependency
        op(1, 1, 2, 1, 3, 0);
        op(3, 1, 1, 1, 9, 0);
        check("b2b_A", 32'(ALUSrcA), 1);
        check("b2b_B", 32'(ALUSrcB), 0);

        // distance 2 and distance 3
        op(1, 1, 2, 1, 5, 0);
        op(7, 1, 8, 1, 6, 0);
        op(9, 1, 5, 1, 10, 0);
        check("dist2_B", 32'(ALUSrcB), 2);
        check("dist2_A", 32'(ALUSrcA), 0);
        op(1, 1, 2, 1, 5, 0);
        op(7, 1, 8, 1, 6, 0);
        op(8, 1, 9, 1, 7, 0);
        op(9, 1, 5, 1, 11, 0);
        check("dist3_B", 32'(ALUSrcB), 0);

        // double match, newest wins
        op(1, 1, 2, 1, 4, 0);
        op(1, 1, 2, 1, 4, 0);
        op(4, 1, 4, 1, 12, 0);
        check("double_A", 32'(ALUSrcA), 1);
        check("double_B", 32'(ALUSrcB), 1);

        // load-use: one stall, bubble, then code 2
        op(1, 1, 0, 0, 2, 1);
        drive(1, 2, 1, 3, 1, 13, 1, 0, 0);
        #1 check("lu_stall_on", 32'(stall), 1);
        tick();
        check("lu_bubble_A", 32'(ALUSrcA), 0);
        check("lu_bubble_B", 32'(ALUSrcB), 0);
        check("lu_stall_off", 32'(stall), 0);
        tick();
        check("lu_after_A", 32'(ALUSrcA), 2);

        // r0 guard, including a load into r0
        op(1, 1, 2, 1, 0, 0);
        op(0, 1, 0, 1, 0, 1);
        check("r0_A", 32'(ALUSrcA), 0);
        check("r0_B", 32'(ALUSrcB), 0);
        drive(1, 0, 1, 0, 1, 3, 1, 0, 0);
        #1 check("r0_load_nostall", 32'(stall), 0);
        tick();

        // flush beats load-use hazard
        op(1, 1, 0, 0, 2, 1);
        drive(1, 2, 1, 2, 1, 14, 1, 0, 1);
        #1 check("flush_stall", 32'(stall), 0);
        tick();
        check("flush_A", 32'(ALUSrcA), 0);
        check("flush_B", 32'(ALUSrcB), 0);

        // reset in the middle of a stall
        op(1, 1, 0, 0, 6, 1);
        drive(1, 6, 1, 0, 0, 15, 1, 0, 0);
        #1 check("rst_mid_stall_on", 32'(stall), 1);
        rst = 1;
        #1 check("rst_mid_stall_off", 32'(stall), 0);
        tick(); tick();
        rst = 0;
        #1 check("rst_exit_stall", 32'(stall), 0);
        tick();
        check("rst_exit_A", 32'(ALUSrcA), 0);
        check("rst_exit_B", 32'(ALUSrcB), 0);

        // mixed directed stream, the model checks each cycle
        begin
            int i = 0;
            int cyc = 0;
            while (i < 48 && cyc < 200) begin
                drive(1, 4'((i * 3) % 5), 1'(i % 3 != 2), 4'((i * 7) % 6), 1'(i % 4 != 3),
                      4'((i * 5) % 5), 1'(i % 5 != 4), 1'(i % 4 == 1), 1'(i % 9 == 8));
                #1;
                if (!m_stall()) i++;
                tick();
                cyc++;
            end
            check("stream_done", 32'(i), 48);
        end

`ifdef FWD_STATS_EN
        // saturation: every instruction reads the previous one's rd
        for (int k = 0; k < 65537; k++) op(3, 1, 0, 0, 3, 0);
        check("sat_fwd_mem_cnt", 32'(fwd_mem_cnt), 32'hFFFF);
`endif

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
